lc3_control_fsm: RTL and testbench

Moore control state machine for the LC-3 datapath. It sequences fetch, decode and execute for a core instruction subset. It drives every load and gate strobe, including ld_ben to the branch-enable register, and consumes the registered ben in the branch state. Memory accesses use a ready handshake with a timeout.

---
 rtl/lc3_control_fsm_if.sv | 55 +++++
 rtl/lc3_control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_control_fsm_if.sv
// Control bus between the LC-3 control FSM (master) and the datapath/memory side (slave).
// The optional step input exists only when LC3_SINGLE_STEP_EN is defined.
interface lc3_control_fsm_if;
    logic       run;
`ifdef LC3_SINGLE_STEP_EN
    logic       step;
`endif
    logic [3:0] ir_opcode;
    logic       ben;
    logic       mem_ready;

    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux_sel;
    logic       addr1mux_sel;
    logic [1:0] addr2mux_sel;
    logic [1:0] aluk;
    logic       mio_en;
    logic       r_w;
    logic       mem_err;
    logic [5:0] state_num;

    // FSM side: consumes status, drives every strobe and select.
    modport master (
`ifdef LC3_SINGLE_STEP_EN
        input  step,
`endif
        input  run, ir_opcode, ben, mem_ready,
        output ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
        output gate_pc, gate_mdr, gate_alu, gate_marmux,
        output pcmux_sel, addr1mux_sel, addr2mux_sel, aluk,
        output mio_en, r_w, mem_err, state_num
    );

    // Datapath/memory side: mirror image of the master.
    modport slave (
`ifdef LC3_SINGLE_STEP_EN
        output step,
`endif
        output run, ir_opcode, ben, mem_ready,
        input  ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
        input  gate_pc, gate_mdr, gate_alu, gate_marmux,
        input  pcmux_sel, addr1mux_sel, addr2mux_sel, aluk,
        input  mio_en, r_w, mem_err, state_num
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore control FSM for the LC-3 datapath (fetch, decode, execute
// for BR, ADD, LD, ST, AND, NOT, JMP, LEA, TRAP-as-halt). Memory states wait on
// mem_ready with a MEM_TIMEOUT-cycle limit; a timeout sets a sticky mem_err and halts.
// Optional macro LC3_SINGLE_STEP_EN adds a step input that runs one instruction
// from HALTED.
module lc3_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    lc3_control_fsm_if.master bus
);

    // Encodings are the LC-3 state numbers so state_num is the state register itself.
    typedef enum logic [5:0] {
        S0     = 6'd0,
        S1     = 6'd1,
        S2     = 6'd2,
        S3     = 6'd3,
        S5     = 6'd5,
        S9     = 6'd9,
        S12    = 6'd12,
        S14    = 6'd14,
        S16    = 6'd16,
        S18    = 6'd18,
        S22    = 6'd22,
        S23    = 6'd23,
        S25    = 6'd25,
        S27    = 6'd27,
        S32    = 6'd32,
        S33    = 6'd33,
        S35    = 6'd35,
        HALTED = 6'd63
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux_sel;
        logic       addr1mux_sel;
        logic [1:0] addr2mux_sel;
        logic [1:0] aluk;
        logic       mio_en;
        logic       r_w;
    } ctl_t;

    // Last wait count at which a still-missing mem_ready turns into a fault.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     next;
    state_t     after_instr;
    ctl_t       ctl;
    logic [7:0] wait_cnt;
    logic       mem_err;
    logic       in_mem;
    logic       timeout;
    logic       start;
    logic       go_on;
`ifdef LC3_SINGLE_STEP_EN
    logic       stepping;
`endif

    // Strobes and selects asserted in each state; anything not listed stays 0.
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S18: begin
                c.ld_mar  = 1'b1;
                c.gate_pc = 1'b1;
                c.ld_pc   = 1'b1;
            end
            S33, S25: begin
                c.mio_en = 1'b1;
                c.ld_mdr = 1'b1;
            end
            S35: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S32: c.ld_ben = 1'b1;
            S22: begin
                c.ld_pc        = 1'b1;
                c.pcmux_sel    = 2'b01;
                c.addr2mux_sel = 2'b01;
            end
            S1, S5, S9: begin
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                c.aluk     = (s == S1) ? 2'b00 : (s == S5) ? 2'b01 : 2'b10;
            end
            S2, S3: begin
                c.gate_marmux  = 1'b1;
                c.ld_mar       = 1'b1;
                c.addr2mux_sel = 2'b01;
            end
            S27: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S23: begin
                c.gate_alu = 1'b1;
                c.aluk     = 2'b11;
                c.ld_mdr   = 1'b1;
            end
            S16: begin
                c.mio_en = 1'b1;
                c.r_w    = 1'b1;
            end
            S12: begin
                c.ld_pc        = 1'b1;
                c.pcmux_sel    = 2'b01;
                c.addr1mux_sel = 1'b1;
            end
            S14: begin
                c.gate_marmux  = 1'b1;
                c.ld_reg       = 1'b1;
                c.addr2mux_sel = 2'b01;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic: sequencing, opcode dispatch and memory wait/timeout decisions.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        next    = state;
        in_mem  = (state == S33) || (state == S25) || (state == S16);
        timeout = in_mem && !bus.mem_ready && (wait_cnt == WAIT_LAST);
`ifdef LC3_SINGLE_STEP_EN
        start       = bus.run || bus.step;
        go_on       = bus.run || stepping;
        after_instr = bus.run ? S18 : HALTED;
`else
        start       = bus.run;
        go_on       = bus.run;
        after_instr = S18;
`endif
        unique case (state)
            HALTED: if (start && !mem_err) next = S18;
            S18:    next = go_on ? S33 : HALTED;
            S33:    if (bus.mem_ready) next = S35; else if (timeout) next = HALTED;
            S35:    next = S32;
            S32: begin
                case (bus.ir_opcode)
                    4'b0000: next = S0;
                    4'b0001: next = S1;
                    4'b0010: next = S2;
                    4'b0011: next = S3;
                    4'b0101: next = S5;
                    4'b1001: next = S9;
                    4'b1100: next = S12;
                    4'b1110: next = S14;
                    4'b1111: next = HALTED;
                    default: next = S18;
                endcase
            end
            S0:     next = bus.ben ? S22 : after_instr;
            S2:     next = S25;
            S25:    if (bus.mem_ready) next = S27; else if (timeout) next = HALTED;
            S3:     next = S23;
            S23:    next = S16;
            S16:    if (bus.mem_ready) next = after_instr; else if (timeout) next = HALTED;
            S1, S5, S9, S12, S14, S22, S27: next = after_instr;
            default: next = HALTED;
        endcase
    end

    // State, registered outputs decoded from the next state, wait counter and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HALTED;
            ctl      <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
`ifdef LC3_SINGLE_STEP_EN
            stepping <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= next;
            ctl   <= decode(next);
            if (timeout)
                mem_err <= 1'b1;
            if (next != state)
                wait_cnt <= '0;
            else if (in_mem)
                wait_cnt <= wait_cnt + 8'd1;
`ifdef LC3_SINGLE_STEP_EN
            if (next == HALTED)
                stepping <= 1'b0;
            else if (state == HALTED && next == S18)
                stepping <= !bus.run;
`endif
        end
    end

    assign bus.ld_mar       = ctl.ld_mar;
    assign bus.ld_mdr       = ctl.ld_mdr;
    assign bus.ld_ir        = ctl.ld_ir;
    assign bus.ld_ben       = ctl.ld_ben;
    assign bus.ld_reg       = ctl.ld_reg;
    assign bus.ld_cc        = ctl.ld_cc;
    assign bus.ld_pc        = ctl.ld_pc;
    assign bus.gate_pc      = ctl.gate_pc;
    assign bus.gate_mdr     = ctl.gate_mdr;
    assign bus.gate_alu     = ctl.gate_alu;
    assign bus.gate_marmux  = ctl.gate_marmux;
    assign bus.pcmux_sel    = ctl.pcmux_sel;
    assign bus.addr1mux_sel = ctl.addr1mux_sel;
    assign bus.addr2mux_sel = ctl.addr2mux_sel;
    assign bus.aluk         = ctl.aluk;
    assign bus.mio_en       = ctl.mio_en;
    assign bus.r_w          = ctl.r_w;
    assign bus.mem_err      = mem_err;
    assign bus.state_num    = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: scoreboard bench for lc3_control_fsm (default build, MEM_TIMEOUT=15).
// Expected state sequences are queued when an instruction is issued and popped one per
// clock; the expected strobes for each state come from a reference table.
module tb_lc3_control_fsm;

    logic clk = 1'b0;
    logic reset;

    lc3_control_fsm_if bus ();

    lc3_control_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux_sel;
        logic       addr1mux_sel;
        logic [1:0] addr2mux_sel;
        logic [1:0] aluk;
        logic       mio_en;
        logic       r_w;
    } ctl_t;

    typedef struct {
        int   st;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mem_delay = 0;
    int   mem_wait = 0;
    int   cnt_ld_ben;
    int   cnt_ld_pc_exec;
    int   cnt_ld_cc;

    // Reference control table, one entry per LC-3 state.
    function automatic ctl_t spec_ctl(int s);
        ctl_t c;
        c = '0;
        case (s)
            18: begin c.ld_mar = 1; c.gate_pc = 1; c.ld_pc = 1; end
            33: begin c.mio_en = 1; c.ld_mdr = 1; end
            25: begin c.mio_en = 1; c.ld_mdr = 1; end
            35: begin c.gate_mdr = 1; c.ld_ir = 1; end
            32: c.ld_ben = 1;
            22: begin c.ld_pc = 1; c.pcmux_sel = 2'b01; c.addr2mux_sel = 2'b01; end
            1:  begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = 2'b00; end
            5:  begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = 2'b01; end
            9:  begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = 2'b10; end
            2:  begin c.gate_marmux = 1; c.ld_mar = 1; c.addr2mux_sel = 2'b01; end
            3:  begin c.gate_marmux = 1; c.ld_mar = 1; c.addr2mux_sel = 2'b01; end
            27: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
            23: begin c.gate_alu = 1; c.aluk = 2'b11; c.ld_mdr = 1; end
            16: begin c.mio_en = 1; c.r_w = 1; end
            12: begin c.ld_pc = 1; c.pcmux_sel = 2'b01; c.addr1mux_sel = 1; end
            14: begin c.gate_marmux = 1; c.ld_reg = 1; c.addr2mux_sel = 2'b01; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c.ld_mar       = bus.ld_mar;
        c.ld_mdr       = bus.ld_mdr;
        c.ld_ir        = bus.ld_ir;
        c.ld_ben       = bus.ld_ben;
        c.ld_reg       = bus.ld_reg;
        c.ld_cc        = bus.ld_cc;
        c.ld_pc        = bus.ld_pc;
        c.gate_pc      = bus.gate_pc;
        c.gate_mdr     = bus.gate_mdr;
        c.gate_alu     = bus.gate_alu;
        c.gate_marmux  = bus.gate_marmux;
        c.pcmux_sel    = bus.pcmux_sel;
        c.addr1mux_sel = bus.addr1mux_sel;
        c.addr2mux_sel = bus.addr2mux_sel;
        c.aluk         = bus.aluk;
        c.mio_en       = bus.mio_en;
        c.r_w          = bus.r_w;
        return c;
    endfunction

    task automatic push(int st, logic err = 1'b0);
        exp_t e;
        e.st  = st;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic push_n(int st, int n, logic err = 1'b0);
        for (int i = 0; i < n; i++) push(st, err);
    endtask

    // Clock until the scoreboard is empty; the memory model answers each access
    // after mem_delay idle cycles. Counters cover the whole drained sequence.
    task automatic drain();
        exp_t e;
        ctl_t obs;
        ctl_t want;
        cnt_ld_ben     = 0;
        cnt_ld_pc_exec = 0;
        cnt_ld_cc      = 0;
        while (sb.size() > 0) begin
            if (bus.mio_en === 1'b1) begin
                bus.mem_ready = (mem_wait >= mem_delay);
                mem_wait      = bus.mem_ready ? 0 : mem_wait + 1;
            end else begin
                bus.mem_ready = 1'b0;
                mem_wait      = 0;
            end
            @(posedge clk);
            @(negedge clk);
            e    = sb.pop_front();
            obs  = observed();
            want = spec_ctl(e.st);
            checks++;
            if (bus.state_num !== 6'(e.st)) begin
                errors++;
                $display("FAIL state_num: got %0d expected %0d", bus.state_num, e.st);
            end
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL controls in state %0d: got %h expected %h", e.st, obs, want);
            end
            checks++;
            if (bus.mem_err !== e.err) begin
                errors++;
                $display("FAIL mem_err in state %0d: got %b expected %b", e.st, bus.mem_err, e.err);
            end
            if (bus.ld_ben === 1'b1) cnt_ld_ben++;
            if (bus.ld_pc === 1'b1 && bus.state_num != 6'd18) cnt_ld_pc_exec++;
            if (bus.ld_cc === 1'b1) cnt_ld_cc++;
        end
    endtask

    task automatic check_count(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.ir_opcode = 4'b0000;
        bus.ben       = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.state_num !== 6'd63) begin
            errors++;
            $display("FAIL reset state_num: got %0d expected 63", bus.state_num);
        end
        checks++;
        if (observed() !== ctl_t'(0)) begin
            errors++;
            $display("FAIL reset controls: got %h expected 0", observed());
        end
        checks++;
        if (bus.mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset mem_err: got %b expected 0", bus.mem_err);
        end
        push_n(63, 2);
        drain();
    endtask

    task automatic test_add();
        mem_delay     = 0;
        bus.run       = 1'b1;
        bus.ir_opcode = 4'b0001;
        push(18); push(33); push(35); push(32); push(1); push(18);
        drain();
        check_count("add ld_ben cycles", cnt_ld_ben, 1);
    endtask

    task automatic test_alu_ops();
        bus.ir_opcode = 4'b0101;
        push(33); push(35); push(32); push(5); push(18);
        drain();
        bus.ir_opcode = 4'b1001;
        push(33); push(35); push(32); push(9); push(18);
        drain();
        bus.ir_opcode = 4'b1110;
        push(33); push(35); push(32); push(14); push(18);
        drain();
        check_count("lea ld_cc cycles", cnt_ld_cc, 0);
        bus.ir_opcode = 4'b1100;
        push(33); push(35); push(32); push(12); push(18);
        drain();
        bus.ir_opcode = 4'b0100;
        push(33); push(35); push(32); push(18);
        drain();
    endtask

    task automatic test_branch();
        bus.ir_opcode = 4'b0000;
        bus.ben       = 1'b1;
        push(33); push(35); push(32); push(0); push(22); push(18);
        drain();
        check_count("br taken ld_pc outside fetch", cnt_ld_pc_exec, 1);
        bus.ben = 1'b0;
        push(33); push(35); push(32); push(0); push(18);
        drain();
        check_count("br not taken ld_pc outside fetch", cnt_ld_pc_exec, 0);
    endtask

    task automatic test_ld_wait();
        mem_delay     = 3;
        bus.ir_opcode = 4'b0010;
        push_n(33, 4); push(35); push(32); push(2); push_n(25, 4); push(27); push(18);
        drain();
    endtask

    task automatic test_st_wait();
        mem_delay     = 3;
        bus.ir_opcode = 4'b0011;
        push_n(33, 4); push(35); push(32); push(3); push(23); push_n(16, 4); push(18);
        drain();
        check_count("st ld_cc cycles", cnt_ld_cc, 0);
    endtask

    task automatic test_back_to_back();
        mem_delay     = 0;
        bus.ir_opcode = 4'b0010;
        push(33); push(35); push(32); push(2); push(25); push(27); push(18);
        drain();
        bus.ir_opcode = 4'b0011;
        push(33); push(35); push(32); push(3); push(23); push(16); push(18);
        drain();
        bus.ir_opcode = 4'b0001;
        push(33); push(35); push(32); push(1); push(18);
        drain();
    endtask

    task automatic test_ready_at_limit();
        mem_delay     = 14;
        bus.ir_opcode = 4'b0001;
        push_n(33, 15); push(35); push(32); push(1); push(18);
        drain();
        mem_delay = 0;
    endtask

    task automatic test_run_stop();
        bus.run = 1'b0;
        push_n(63, 3);
        drain();
        bus.run = 1'b1;
        push(18);
        drain();
    endtask

    task automatic test_trap();
        bus.ir_opcode = 4'b1111;
        push(33); push(35); push(32); push(63); push(18);
        drain();
    endtask

    task automatic test_reset_mid_store();
        mem_delay     = 2;
        bus.ir_opcode = 4'b0011;
        push_n(33, 3); push(35); push(32); push(3); push(23); push_n(16, 2);
        drain();
        #2 reset = 1'b1;
        bus.run = 1'b0;
        #1;
        checks++;
        if (bus.mio_en !== 1'b0) begin
            errors++;
            $display("FAIL mid-store reset mio_en: got %b expected 0", bus.mio_en);
        end
        checks++;
        if (bus.state_num !== 6'd63) begin
            errors++;
            $display("FAIL mid-store reset state_num: got %0d expected 63", bus.state_num);
        end
        @(negedge clk);
        reset     = 1'b0;
        mem_delay = 0;
    endtask

    task automatic test_timeout();
        mem_delay     = 255;
        bus.run       = 1'b1;
        bus.ir_opcode = 4'b0001;
        push(18); push_n(33, 15); push_n(63, 3, 1'b1);
        drain();
        apply_reset();
        checks++;
        if (bus.mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_err after reset: got %b expected 0", bus.mem_err);
        end
        mem_delay     = 0;
        bus.run       = 1'b1;
        bus.ir_opcode = 4'b0001;
        push(18); push(33); push(35); push(32); push(1); push(18);
        drain();
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_ld_wait();
        test_st_wait();
        test_back_to_back();
        test_ready_at_limit();
        test_run_stop();
        test_trap();
        test_reset_mid_store();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
